// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared types and constants for the mux select sequencer
`timescale 1ns/1ns
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int N_INPUTS = 4;
  localparam int SEL_W    = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t LAST_SEL = sel_t'(N_INPUTS - 1);

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - settle-time counter; pre_tc port only with SAMPLE_CHECK_EN
`timescale 1ns/1ns
module settle_counter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
`ifdef SAMPLE_CHECK_EN
  output logic pre_tc,
`endif
  output logic tc
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else              cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(SETTLE_CYCLES - 1));

`ifdef SAMPLE_CHECK_EN
  // One cycle before terminal count; never fires when settling is a single cycle.
  localparam int PRE_CNT = (SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0;
  assign pre_tc = (SETTLE_CYCLES >= 2) && (cnt == CNT_W'(PRE_CNT));
`endif

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - steps mux select through 4 inputs, samples w after settling; optional err via SAMPLE_CHECK_EN
`timescale 1ns/1ns
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       w,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] data
`ifdef SAMPLE_CHECK_EN
  ,
  output logic       err
`endif
);

  state_t              state;
  sel_t                sel;
  logic [N_INPUTS-2:0] staging;
  logic                tc;
  logic                clear;

  // Counter only runs while settling and restarts after each sample.
  assign clear = (state != SETTLE) || tc;

`ifdef SAMPLE_CHECK_EN
  localparam bit CHECK_ON = (SETTLE_CYCLES >= 2);

  logic pre_tc;
  logic early;
  logic bad_sample;

  assign bad_sample = CHECK_ON && ((early !== w) || (w !== 1'b0 && w !== 1'b1));
`endif

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
`ifdef SAMPLE_CHECK_EN
    .pre_tc(pre_tc),
`endif
    .tc    (tc)
  );

  assign s0 = sel[0];
  assign s1 = sel[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      data    <= '0;
      staging <= '0;
`ifdef SAMPLE_CHECK_EN
      early   <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            sel   <= '0;
            busy  <= 1'b1;
`ifdef SAMPLE_CHECK_EN
            err   <= 1'b0;
`endif
          end
        end
        SETTLE: begin
`ifdef SAMPLE_CHECK_EN
          if (pre_tc) early <= w;
`endif
          if (tc) begin
`ifdef SAMPLE_CHECK_EN
            if (bad_sample) err <= 1'b1;
`endif
            if (sel == LAST_SEL) begin
              // Last bit goes straight into data; staging holds only the first three.
              state <= DONE;
              data  <= {w, staging};
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              staging[sel] <= w;
              sel          <= sel + sel_t'(1);
            end
          end
        end
        DONE: begin
          sel <= '0;
          if (start) begin
            state <= SETTLE;
            busy  <= 1'b1;
`ifdef SAMPLE_CHECK_EN
            err   <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - scoreboard bench for mux_select_sequencer (S=4 and S=1 instances)
`timescale 1ns/1ns
module tb_mux_select_sequencer;

  localparam int S = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       start  = 1'b0;
  logic       start1 = 1'b0;
  logic [3:0] mux_in = 4'b0000;
  logic       w, w1;
  logic       s0, s1, busy, done;
  logic       s0b, s1b, busy1, done1;
  logic [3:0] data, data1;
`ifdef SAMPLE_CHECK_EN
  logic       err, err1;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [3:0] sb[$];
  logic [3:0] sb1[$];
  logic [3:0] last_data = 4'b0000;
  logic [3:0] mon_exp;
  logic [3:0] exp1;

  always #5 clk = ~clk;

  // Zero-delay behavioural stand-in for the 4-to-1 mux: input i is mux_in[i].
  assign w  = mux_in[{s1, s0}];
  assign w1 = mux_in[{s1b, s0b}];

  mux_select_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .w    (w),
    .s0   (s0),
    .s1   (s1),
    .busy (busy),
    .done (done),
    .data (data)
`ifdef SAMPLE_CHECK_EN
    ,
    .err  (err)
`endif
  );

  mux_select_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .w    (w1),
    .s0   (s0b),
    .s1   (s1b),
    .busy (busy1),
    .done (done1),
    .data (data1)
`ifdef SAMPLE_CHECK_EN
    ,
    .err  (err1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every done pulse must match the oldest outstanding scan.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        check("data", 32'(data), 32'(mon_exp));
`ifdef SAMPLE_CHECK_EN
        check("err", 32'(err), 32'd0);
`endif
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sel", 32'({s1, s0}), 32'd0);
      check("idle_data", 32'(data), 32'(last_data));
    end
  endtask

  // Called at a negedge; the next posedge is E0.
  task automatic scan(input logic [3:0] ins, input bit keep, input bit poke);
    mux_in = ins;
    start  = 1'b1;
    @(posedge clk);
    sb.push_back(ins);
    @(negedge clk);
    start = keep;
    for (int j = 0; j < 4 * S; j++) begin
      check("scan_busy", 32'(busy), 32'd1);
      check("scan_done_lo", 32'(done), 32'd0);
      check("scan_sel", 32'({s1, s0}), 32'(j / S));
      check("scan_data_hold", 32'(data), 32'(last_data));
      if (poke) start = (j == 5);
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_sel", 32'({s1, s0}), 32'd3);
    last_data = ins;
  endtask

  task automatic scan1(input logic [3:0] ins);
    mux_in = ins;
    start1 = 1'b1;
    @(posedge clk);
    sb1.push_back(ins);
    @(negedge clk);
    start1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("s1_busy", 32'(busy1), 32'd1);
      check("s1_sel", 32'({s1b, s0b}), 32'(j));
      check("s1_done_lo", 32'(done1), 32'd0);
      @(negedge clk);
    end
    exp1 = sb1.pop_front();
    check("s1_done", 32'(done1), 32'd1);
    check("s1_data", 32'(data1), 32'(exp1));
`ifdef SAMPLE_CHECK_EN
    check("s1_err", 32'(err1), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'({s1, s0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst = 1'b0;
    idle(3);

    // a=0 b=1 c=1 d=0
    scan(4'b0110, 1'b0, 1'b0);
    idle(2);

    // start held: back-to-back scans every 4S+1 cycles
    scan(4'b0110, 1'b1, 1'b0);
    scan(4'b0110, 1'b1, 1'b0);
    scan(4'b0110, 1'b0, 1'b0);
    idle(2);

    // Reset mid-scan with sel=2: abandoned, no done
    start = 1'b1;
    @(posedge clk);
    sb.push_back(4'b0110);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_sel", 32'({s1, s0}), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'({s1, s0}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    sb.delete();
    last_data = 4'b0000;
    rst = 1'b0;
    idle(4);
    scan(4'b0110, 1'b0, 1'b0);

    // a=1 b=0 c=0 d=1, with stray start pulses during SETTLE
    scan(4'b1001, 1'b0, 1'b1);
    idle(3);

    // Single-cycle settle instance
    scan1(4'b1101);
    scan1(4'b0010);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Clocked control stage that sits directly upstream of the switch-level 4-to-1 tristate mux (mux_4to1).
- Drives the mux select lines s1/s0 through all four inputs and waits a programmable settle time after each select change, because the transistor-level mux has multi-ns propagation.
- Samples the mux output w once per input and presents the four captured bits as one word, with a busy/done handshake.
- Timescale 1ns/1ns, like the rest of the switch-level blocks.

Parameters:
- SETTLE_CYCLES, 4, clock cycles between a select change and the sampling of w; legal range 1..255.
- CNT_W, $clog2(SETTLE_CYCLES+1), width of the settle counter; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; requests one scan when the block is accepting.
- w  input  1  mux output being sampled.
- s0  output  1  select LSB to the mux.
- s1  output  1  select MSB to the mux.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when data is updated.
- data  output  4  captured word: data[i] = w sampled while {s1,s0}==i.

Behaviour:
- Reset (synchronous, active-high, sampled at the clk edge):
  - state=IDLE; s0=s1=0; busy=0; done=0; data=4'b0000; counter=0.
  - Overrides everything, including a scan in progress; a scan in flight is abandoned with no done.
- States: IDLE, SETTLE, DONE.
  - IDLE: outputs hold. start=1 at edge E0 moves to SETTLE with sel=0, cnt=0, busy=1.
  - SETTLE: cnt increments each edge. At the edge where cnt==SETTLE_CYCLES-1:
    - w is written into staging[sel] and cnt clears.
    - If sel<3: sel increments.
    - If sel==3: go to DONE, data<=staging including the bit sampled this edge, done<=1, busy<=0.
  - DONE: lasts exactly one cycle.
    - If start=1, a new scan begins (back-to-back).
    - Otherwise return to IDLE.
    - sel returns to 0 in both cases.
- Latency: samples at E0+S, E0+2S, E0+3S, E0+4S (S=SETTLE_CYCLES). done is high during the cycle after edge E0+4S. Back-to-back period is 4S+1 cycles.
- data changes only on the done edge and stays stable while busy.
- start is ignored while in SETTLE.
- {s1,s0} are registered outputs equal to sel and change only on clock edges, so the mux sees one select change per step.
- S=1: one sample per cycle, with sel stepping every edge.
- X/Z on w is captured as-is.

Optional Feature:
- Macro SAMPLE_CHECK_EN, compiled in when defined.
- Adds output err (1 bit, reset 0).
- While in SETTLE, w is also captured at cnt==SETTLE_CYCLES-2, and err is set when:
  - that early capture differs from the final sample (`!==`), or
  - the final sample is X/Z.
- err is sticky within a scan, cleared when a new scan starts, and valid alongside done.
- The check is inactive when SETTLE_CYCLES==1.
- Without the macro: no err port and no extra registers.

Decomposition:
- Package mux_seq_pkg:
  - state_t enum {IDLE, SETTLE, DONE};
  - localparams N_INPUTS=4 and SEL_W=2;
  - sel_t typedef logic [SEL_W-1:0].
- Natural sub-module settle_counter (parameter SETTLE_CYCLES, clk/rst/clear inputs, terminal-count output). The FSM stays in mux_select_sequencer.

Test Plan:
- Bench setup: 10 ns clock, S=4, DUT driving mux_4to1 with a=0, b=1, c=1, d=0.
- Reset, then start pulsed at E0 -> {s1,s0} steps 00,01,10,11 every 4 cycles; done one cycle after edge E0+16; data=4'b0110; busy high for exactly 16 cycles.
- start held high -> back-to-back scans every 17 cycles; data remains 4'b0110 each scan; done pulses exactly once per scan.
- rst asserted at E0+9, mid-scan with sel=2 -> next edge: s0=s1=0, busy=0, data=0000, no done; a later start gives a full correct scan.
- Change to a=1, b=0, c=0, d=1, then start -> data=4'b1001. start pulses inside SETTLE have no effect on timing.
- S=1 with the mux replaced by a 0-delay model -> done one cycle after E0+4; data matches the inputs.
- SAMPLE_CHECK_EN with S=2 and a 10 ns clock (settle shorter than mux delay) -> err=1 with done; with S=4 -> err=0.
